// File: rtl/boot_pkg.sv
// Shared types and constants for the ROM-to-RAM boot copier.
// The state encoding is fixed so that it stays stable in waveforms and netlists.
package boot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } boot_state_t;

    localparam logic [31:0] DEST_BASE_DEFAULT = 32'h1000_0000;
    localparam logic [3:0]  WSTRB_FULL        = 4'hF;

endpackage

// File: rtl/rom_boot_copier.sv
// Boot sequencer: copies the ROM image word by word into RAM while holding the core in reset,
// then releases the core and reports the number of words written and their wrapping checksum.
module rom_boot_copier
    import boot_pkg::*;
#(
    parameter int          ROM_DEPTH    = 128,
    parameter logic [31:0] DEST_BASE    = DEST_BASE_DEFAULT,
    parameter bit          STOP_ON_ZERO = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [11:0]                rom_addr,
    input  logic [31:0]                rom_inst,
    output logic                       mem_req,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_wstrb,
    input  logic                       mem_ready,
    input  logic                       reboot,
    output logic                       core_reset,
    output logic                       boot_done,
    output logic [$clog2(ROM_DEPTH):0] word_count,
    output logic [31:0]                checksum
);

    localparam int                IDX_W    = $clog2(ROM_DEPTH);
    localparam int                CNT_W    = IDX_W + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROM_DEPTH - 1);

    boot_state_t      state;
    logic [IDX_W-1:0] index;
    logic             stop_here;

    function automatic logic [31:0] byte_offset(input logic [IDX_W-1:0] idx);
        return 32'({idx, 2'b00});
    endfunction

    assign stop_here = STOP_ON_ZERO && (rom_inst == 32'h0000_0000);

    // Every output is a register; the write port fields are loaded on leaving READ
    // and stay frozen until the RAM accepts, which keeps them stable across stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            index      <= '0;
            rom_addr   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            core_reset <= 1'b1;
            boot_done  <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    index      <= '0;
                    rom_addr   <= '0;
                    word_count <= '0;
                    checksum   <= '0;
                    state      <= READ;
                end

                READ: begin
                    if (stop_here) begin
                        core_reset <= 1'b0;
                        boot_done  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        mem_wdata <= rom_inst;
                        mem_addr  <= DEST_BASE + byte_offset(index);
                        mem_req   <= 1'b1;
                        mem_wstrb <= WSTRB_FULL;
                        state     <= WRITE;
                    end
                end

                WRITE: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        mem_wstrb  <= '0;
                        checksum   <= checksum + mem_wdata;
                        word_count <= word_count + CNT_W'(1);
                        // The last index goes straight to DONE so the index never wraps.
                        if (index == LAST_IDX) begin
                            core_reset <= 1'b0;
                            boot_done  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            index    <= index + IDX_W'(1);
                            rom_addr <= 12'(byte_offset(index + IDX_W'(1)));
                            state    <= READ;
                        end
                    end
                end

                DONE: begin
                    if (reboot) begin
                        core_reset <= 1'b1;
                        boot_done  <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_boot_copier.sv
// Directed bench for rom_boot_copier: full copy, zero terminator, stalls, reset mid-copy and reboot.
module tb_rom_boot_copier;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        mem_ready;
    logic        reboot;

    logic [11:0] rom_addr;
    logic [31:0] rom_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        core_reset;
    logic        boot_done;
    logic [7:0]  word_count;
    logic [31:0] checksum;

    logic [11:0] nz_rom_addr;
    logic [31:0] nz_rom_inst;
    logic        nz_mem_req;
    logic [31:0] nz_mem_addr;
    logic [31:0] nz_mem_wdata;
    logic [3:0]  nz_mem_wstrb;
    logic        nz_core_reset;
    logic        nz_boot_done;
    logic [7:0]  nz_word_count;
    logic [31:0] nz_checksum;

    logic [31:0] rom_img [0:127];
    logic [9:0]  widx;
    logic [9:0]  nz_widx;

    int n_checks;
    int n_pass;

    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [3:0]  wr_strb [$];

    logic [31:0] stall_addr;
    logic [31:0] stall_expect;
    int          stall_left;
    int          stall_seen;
    int          stall_bad;
    logic [31:0] reboot_addr;
    bit          reboot_pulsed;

    rom_boot_copier #(.ROM_DEPTH(128), .DEST_BASE(BASE), .STOP_ON_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .reboot(reboot), .core_reset(core_reset), .boot_done(boot_done),
        .word_count(word_count), .checksum(checksum)
    );

    rom_boot_copier #(.ROM_DEPTH(128), .DEST_BASE(BASE), .STOP_ON_ZERO(1'b0)) dut_nz (
        .clk(clk), .reset(reset), .rom_addr(nz_rom_addr), .rom_inst(nz_rom_inst),
        .mem_req(nz_mem_req), .mem_addr(nz_mem_addr), .mem_wdata(nz_mem_wdata), .mem_wstrb(nz_mem_wstrb),
        .mem_ready(mem_ready), .reboot(reboot), .core_reset(nz_core_reset), .boot_done(nz_boot_done),
        .word_count(nz_word_count), .checksum(nz_checksum)
    );

    assign widx        = rom_addr[11:2];
    assign nz_widx     = nz_rom_addr[11:2];
    assign rom_inst    = (widx < 10'd128) ? rom_img[widx[6:0]] : 32'h0;
    assign nz_rom_inst = (nz_widx < 10'd128) ? rom_img[nz_widx[6:0]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_image(input int zero_at);
        for (int i = 0; i < 128; i++)
            rom_img[i] = (i == zero_at) ? 32'h0 : 32'(i + 1);
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        wr_strb.delete();
        stall_addr    = NONE;
        stall_left    = 0;
        stall_seen    = 0;
        stall_bad     = 0;
        reboot_addr   = NONE;
        reboot_pulsed = 0;
    endtask

    task automatic start_boot();
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        reboot    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    // Runs from a negedge until boot_done, counting posedges; stalls, reboot pulses and
    // an early exit on a given write address are driven from the globals above.
    task automatic run_until_done(input int max_edges, input logic [31:0] abort_addr,
                                  output int edges, output bit aborted);
        edges   = 0;
        aborted = 0;
        while (boot_done !== 1'b1 && edges < max_edges) begin
            reboot = 1'b0;
            if (mem_req === 1'b1 && mem_addr === abort_addr) begin
                aborted = 1;
                return;
            end
            if (mem_req === 1'b1 && mem_addr === stall_addr && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
                stall_seen++;
                if (mem_wdata !== stall_expect) stall_bad++;
            end else begin
                mem_ready = 1'b1;
            end
            if (mem_req === 1'b1 && mem_ready === 1'b1) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
                wr_strb.push_back(mem_wstrb);
            end
            if (mem_req === 1'b1 && mem_addr === reboot_addr && !reboot_pulsed) begin
                reboot        = 1'b1;
                reboot_pulsed = 1;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        reboot    = 1'b0;
        mem_ready = 1'b1;
    endtask

    function automatic int first_bad_write(input int n);
        for (int i = 0; i < n; i++) begin
            if (i >= wr_addr.size()) return i;
            if (wr_addr[i] !== BASE + 32'(4 * i) || wr_data[i] !== 32'(i + 1) || wr_strb[i] !== 4'hF)
                return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        reboot    = 1'b0;
        load_image(-1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rom_addr, mem_req, mem_addr, mem_wdata, mem_wstrb} !== 81'h0)
            $display("[TB] FAIL reset_mem_port: got addr=%h req=%b maddr=%h wdata=%h strb=%h required all zero",
                     rom_addr, mem_req, mem_addr, mem_wdata, mem_wstrb);
        else n_pass++;
        n_checks++;
        if (core_reset !== 1'b1 || boot_done !== 1'b0)
            $display("[TB] FAIL reset_core: got core_reset=%b boot_done=%b required 1/0", core_reset, boot_done);
        else n_pass++;
        n_checks++;
        if (word_count !== 8'd0 || checksum !== 32'd0)
            $display("[TB] FAIL reset_counters: got count=%0d sum=%0d required 0/0", word_count, checksum);
        else n_pass++;
    endtask

    task automatic test_full_copy();
        int edges;
        bit aborted;
        int bad;
        load_image(-1);
        start_boot();
        run_until_done(400, NONE, edges, aborted);
        bad = first_bad_write(128);
        n_checks++;
        if (edges !== 257)
            $display("[TB] FAIL full_done_edge: got %0d required 257", edges);
        else n_pass++;
        n_checks++;
        if (wr_addr.size() !== 128 || bad !== -1)
            $display("[TB] FAIL full_write_seq: got %0d writes, first bad index %0d, required 128 and -1",
                     wr_addr.size(), bad);
        else n_pass++;
        n_checks++;
        if (word_count !== 8'd128 || checksum !== 32'd8256)
            $display("[TB] FAIL full_totals: got count=%0d sum=%0d required 128/8256", word_count, checksum);
        else n_pass++;
        n_checks++;
        if (core_reset !== 1'b0 || mem_req !== 1'b0 || mem_wstrb !== 4'h0)
            $display("[TB] FAIL full_done_outputs: got core_reset=%b req=%b strb=%h required 0/0/0",
                     core_reset, mem_req, mem_wstrb);
        else n_pass++;
        n_checks++;
        if (nz_boot_done !== 1'b1 || nz_checksum !== 32'd8256)
            $display("[TB] FAIL nz_full_copy: got done=%b sum=%0d required 1/8256", nz_boot_done, nz_checksum);
        else n_pass++;
    endtask

    task automatic test_zero_terminator();
        int edges;
        bit aborted;
        int bad;
        int n;
        load_image(5);
        start_boot();
        run_until_done(400, NONE, edges, aborted);
        bad = first_bad_write(5);
        n_checks++;
        if (edges !== 12)
            $display("[TB] FAIL zterm_done_edge: got %0d required 12", edges);
        else n_pass++;
        n_checks++;
        if (wr_addr.size() !== 5 || bad !== -1)
            $display("[TB] FAIL zterm_writes: got %0d writes, first bad %0d, required 5 and -1", wr_addr.size(), bad);
        else n_pass++;
        n_checks++;
        if (word_count !== 8'd5 || checksum !== 32'd15 || core_reset !== 1'b0)
            $display("[TB] FAIL zterm_totals: got count=%0d sum=%0d core_reset=%b required 5/15/0",
                     word_count, checksum, core_reset);
        else n_pass++;
        // The STOP_ON_ZERO=0 instance must copy the zero word and keep going.
        n = 0;
        while (nz_boot_done !== 1'b1 && n < 400) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        n_checks++;
        if (nz_boot_done !== 1'b1 || nz_word_count !== 8'd128 || nz_checksum !== 32'd8250)
            $display("[TB] FAIL nz_zero_copied: got done=%b count=%0d sum=%0d required 1/128/8250",
                     nz_boot_done, nz_word_count, nz_checksum);
        else n_pass++;
    endtask

    task automatic test_stall();
        int edges;
        bit aborted;
        int bad;
        load_image(-1);
        start_boot();
        stall_addr   = BASE + 32'h8;
        stall_expect = 32'd3;
        stall_left   = 3;
        run_until_done(400, NONE, edges, aborted);
        bad = first_bad_write(128);
        n_checks++;
        if (edges !== 260)
            $display("[TB] FAIL stall_done_edge: got %0d required 260", edges);
        else n_pass++;
        n_checks++;
        if (stall_seen !== 3 || stall_bad !== 0)
            $display("[TB] FAIL stall_hold: got %0d stall cycles, %0d with wrong data, required 3 and 0",
                     stall_seen, stall_bad);
        else n_pass++;
        n_checks++;
        if (wr_addr.size() !== 128 || bad !== -1 || checksum !== 32'd8256)
            $display("[TB] FAIL stall_write_seq: got %0d writes, first bad %0d, sum=%0d required 128/-1/8256",
                     wr_addr.size(), bad, checksum);
        else n_pass++;
    endtask

    task automatic test_reset_mid_copy();
        int edges;
        bit aborted;
        int bad;
        load_image(-1);
        start_boot();
        run_until_done(400, BASE + 32'hA0, edges, aborted);
        n_checks++;
        if (aborted !== 1'b1 || word_count !== 8'd40 || mem_wdata !== 32'd41)
            $display("[TB] FAIL midreset_reach_w40: got reached=%b count=%0d wdata=%0d required 1/40/41",
                     aborted, word_count, mem_wdata);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || core_reset !== 1'b1 || boot_done !== 1'b0)
            $display("[TB] FAIL midreset_outputs: got req=%b core_reset=%b done=%b required 0/1/0",
                     mem_req, core_reset, boot_done);
        else n_pass++;
        n_checks++;
        if (word_count !== 8'd0 || checksum !== 32'd0 || rom_addr !== 12'd0 || mem_addr !== 32'd0)
            $display("[TB] FAIL midreset_counters: got count=%0d sum=%0d rom=%h maddr=%h required all zero",
                     word_count, checksum, rom_addr, mem_addr);
        else n_pass++;
        reset = 1'b0;
        clear_logs();
        run_until_done(400, NONE, edges, aborted);
        bad = first_bad_write(128);
        n_checks++;
        if (edges !== 257 || wr_addr.size() !== 128 || bad !== -1 || checksum !== 32'd8256)
            $display("[TB] FAIL midreset_restart: got edges=%0d writes=%0d bad=%0d sum=%0d required 257/128/-1/8256",
                     edges, wr_addr.size(), bad, checksum);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int edges;
        bit aborted;
        int bad;
        reboot = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reboot = 1'b0;
        n_checks++;
        if (core_reset !== 1'b1 || boot_done !== 1'b0)
            $display("[TB] FAIL reboot_edge: got core_reset=%b done=%b required 1/0", core_reset, boot_done);
        else n_pass++;
        clear_logs();
        run_until_done(400, NONE, edges, aborted);
        bad = first_bad_write(128);
        n_checks++;
        if (edges !== 257 || wr_addr.size() !== 128 || bad !== -1)
            $display("[TB] FAIL reboot_repeat_seq: got edges=%0d writes=%0d bad=%0d required 257/128/-1",
                     edges, wr_addr.size(), bad);
        else n_pass++;
        n_checks++;
        if (word_count !== 8'd128 || checksum !== 32'd8256)
            $display("[TB] FAIL reboot_repeat_totals: got count=%0d sum=%0d required 128/8256", word_count, checksum);
        else n_pass++;
    endtask

    task automatic test_reboot_during_write();
        int edges;
        bit aborted;
        int bad;
        load_image(-1);
        start_boot();
        reboot_addr = BASE + 32'h40;
        run_until_done(400, NONE, edges, aborted);
        bad = first_bad_write(128);
        n_checks++;
        if (reboot_pulsed !== 1'b1 || edges !== 257 || bad !== -1 || checksum !== 32'd8256)
            $display("[TB] FAIL reboot_ignored: got pulsed=%b edges=%0d bad=%0d sum=%0d required 1/257/-1/8256",
                     reboot_pulsed, edges, bad, checksum);
        else n_pass++;
    endtask

    task automatic test_zero_first();
        int edges;
        bit aborted;
        load_image(0);
        start_boot();
        run_until_done(40, NONE, edges, aborted);
        n_checks++;
        if (edges !== 2 || wr_addr.size() !== 0)
            $display("[TB] FAIL zero_first_timing: got edges=%0d writes=%0d required 2/0", edges, wr_addr.size());
        else n_pass++;
        n_checks++;
        if (word_count !== 8'd0 || checksum !== 32'd0 || boot_done !== 1'b1 || core_reset !== 1'b0)
            $display("[TB] FAIL zero_first_state: got count=%0d sum=%0d done=%b core_reset=%b required 0/0/1/0",
                     word_count, checksum, boot_done, core_reset);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear_logs();
        test_reset();
        test_full_copy();
        test_zero_terminator();
        test_stall();
        test_reset_mid_copy();
        test_back_to_back();
        test_reboot_during_write();
        test_zero_first();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
